// File: rtl/int_timer_ctrl.sv
// Interrupt and stable-timer controller: timer CSRs (TID/TCFG/TVAL/TICLR), ESTAT.IS assembly, request FSM.
// Optional build macro INT_HW_SYNC_EN selects a two-flop hw_int_raw synchronizer (default: single stage).
module int_timer_ctrl #(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  hw_int_raw,
  input  logic        ipi_int_in,
  input  logic [1:0]  sw_is,
  input  logic        crmd_ie,
  input  logic [12:0] ecfg_lie,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        int_ack,
  output logic [31:0] csr_rvalue,
  output logic [12:0] estat_is,
  output logic        has_int
);

  // state   | meaning
  // IDLE    | no request outstanding
  // REQ     | has_int raised, waiting for WB to commit
  // HOLD    | one quiet cycle while csr clears CRMD.IE
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} state_t;

  localparam logic [13:0] CSR_TID   = 14'h40;
  localparam logic [13:0] CSR_TCFG  = 14'h41;
  localparam logic [13:0] CSR_TVAL  = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;

  logic [31:0] tid, tcfg, tval;
  logic        ti;
  logic [7:0]  hw_q;
  logic        wr_tid, wr_tcfg, wr_ticlr, timer_fire, pend;
  logic [31:0] tid_new, tcfg_new;
  state_t      state, state_nxt;

  assign wr_tid   = csr_we && (csr_num == CSR_TID);
  assign wr_tcfg  = csr_we && (csr_num == CSR_TCFG);
  assign wr_ticlr = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];
  assign tid_new  = (tid  & ~csr_wmask) | (csr_wvalue & csr_wmask);
  assign tcfg_new = (tcfg & ~csr_wmask) | (csr_wvalue & csr_wmask);
  // A TCFG write in the same cycle pre-empts the expiry, so TI is not set.
  assign timer_fire = tcfg[0] && !wr_tcfg && (tval == 32'h0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tid  <= TID_RESET;
      tcfg <= 32'h0;
      tval <= 32'h0;
      ti   <= 1'b0;
    end else begin
      if (wr_tid)
        tid <= tid_new;
      if (wr_tcfg) begin
        tcfg <= tcfg_new;
        tval <= {tcfg_new[31:2], 2'b00};
      end else if (tcfg[0]) begin
        if (tval != 32'h0)
          tval <= tval - 32'd1;
        else if (tcfg[1])
          tval <= {tcfg[31:2], 2'b00};
        else begin
          tval    <= 32'hFFFF_FFFF;
          tcfg[0] <= 1'b0;
        end
      end
      if (timer_fire)
        ti <= 1'b1;
      else if (wr_ticlr)
        ti <= 1'b0;
    end
  end

`ifdef INT_HW_SYNC_EN
  logic [7:0] hw_meta;
  always_ff @(posedge clk) begin
    if (reset) begin
      hw_meta <= 8'h0;
      hw_q    <= 8'h0;
    end else begin
      hw_meta <= hw_int_raw;
      hw_q    <= hw_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset)
      hw_q <= 8'h0;
    else
      hw_q <= hw_int_raw;
  end
`endif

  assign estat_is = {ipi_int_in, ti, 1'b0, hw_q, sw_is};
  assign pend     = (|(estat_is & ecfg_lie)) & crmd_ie;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    has_int   = 1'b0;
    case (state)
      ST_IDLE: if (pend) state_nxt = ST_REQ;
      ST_REQ: begin
        has_int = 1'b1;
        if (int_ack)
          state_nxt = ST_HOLD;
        else if (!pend)
          state_nxt = ST_IDLE;
      end
      ST_HOLD: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_num)
      CSR_TID:  csr_rvalue = tid;
      CSR_TCFG: csr_rvalue = tcfg;
      CSR_TVAL: csr_rvalue = tval;
      default:  csr_rvalue = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_int_timer_ctrl.sv
// Self-checking bench for int_timer_ctrl: directed timer/interrupt steps plus a randomized interrupt phase.
module tb_int_timer_ctrl;

`ifdef INT_HW_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif
  localparam logic [31:0] TID_RST = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  hw_int_raw;
  logic        ipi_int_in;
  logic [1:0]  sw_is;
  logic        crmd_ie;
  logic [12:0] ecfg_lie;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        int_ack;
  logic [31:0] csr_rvalue;
  logic [12:0] estat_is;
  logic        has_int;

  int errors = 0;
  int checks = 0;

  int_timer_ctrl #(.TID_RESET(TID_RST)) dut (
    .clk(clk), .reset(reset), .hw_int_raw(hw_int_raw), .ipi_int_in(ipi_int_in),
    .sw_is(sw_is), .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie), .csr_we(csr_we),
    .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .int_ack(int_ack), .csr_rvalue(csr_rvalue), .estat_is(estat_is), .has_int(has_int)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [13:0] n, output logic [31:0] v);
    csr_we  = 1'b0;
    csr_num = n;
    #1;
    v = csr_rvalue;
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
    csr_we = 1'b1; csr_num = n; csr_wmask = m; csr_wvalue = v;
    step();
    csr_we = 1'b0;
  endtask

  function automatic logic [31:0] ti_bit();
    return {31'b0, estat_is[11]};
  endfunction

  initial begin
    logic [31:0] v, m, wv, tid_m;
    logic [12:0] exp_is;
    logic [7:0]  hwq[$];
    logic        m_has, m_hold, pend;

    reset = 1'b1; hw_int_raw = '0; ipi_int_in = 1'b0; sw_is = 2'b01; crmd_ie = 1'b0;
    ecfg_lie = '0; csr_we = 1'b0; csr_num = '0; csr_wmask = '0; csr_wvalue = '0; int_ack = 1'b0;
    step(); step();
    rd(14'h40, v); chk("rst_tid", v, TID_RST);
    rd(14'h41, v); chk("rst_tcfg", v, 32'h0);
    rd(14'h42, v); chk("rst_tval", v, 32'h0);
    chk("rst_estat", {19'b0, estat_is}, {30'b0, sw_is});
    chk("rst_has_int", {31'b0, has_int}, 32'h0);
    reset = 1'b0; sw_is = 2'b00;
    step();

    // Masked TID writes against a plain masked-merge model
    tid_m = TID_RST;
    for (int i = 0; i < 6; i++) begin
      m = $urandom; wv = $urandom;
      wr(14'h40, m, wv);
      tid_m = (tid_m & ~m) | (wv & m);
      rd(14'h40, v); chk("tid_masked", v, tid_m);
    end
    wr(14'h42, 32'hFFFF_FFFF, 32'h1234_5678);
    rd(14'h42, v); chk("tval_ro", v, 32'h0);
    rd(14'h44, v); chk("ticlr_rd0", v, 32'h0);
    rd(14'h10, v); chk("other_rd0", v, 32'h0);

    // One-shot, InitVal 4: TVAL 16..0, TI at N+18
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0011);
    for (int j = 1; j <= 17; j++) begin
      rd(14'h42, v); chk("os_tval", v, 32'(16 - (j - 1)));
      chk("os_ti_low", ti_bit(), 32'h0);
      step();
    end
    chk("os_ti_set", ti_bit(), 32'h1);
    rd(14'h42, v); chk("os_tval_ff", v, 32'hFFFF_FFFF);
    rd(14'h41, v); chk("os_en_clr", v, 32'h0000_0010);
    wr(14'h44, 32'h1, 32'h1);
    chk("os_ticlr", ti_bit(), 32'h0);
    for (int j = 0; j < 5; j++) step();
    chk("os_once", ti_bit(), 32'h0);
    rd(14'h42, v); chk("os_tval_hold", v, 32'hFFFF_FFFF);

    // Periodic, InitVal 2
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
    rd(14'h42, v); chk("per_load", v, 32'd8);
    for (int j = 0; j < 8; j++) step();
    rd(14'h42, v); chk("per_zero", v, 32'h0);
    chk("per_ti_pre", ti_bit(), 32'h0);
    step();
    chk("per_ti_set", ti_bit(), 32'h1);
    rd(14'h42, v); chk("per_reload", v, 32'd8);
    wr(14'h44, 32'h1, 32'h1);
    chk("per_clr", ti_bit(), 32'h0);
    rd(14'h42, v); chk("per_tval7", v, 32'd7);
    for (int j = 0; j < 7; j++) step();
    chk("per_ti_pre2", ti_bit(), 32'h0);
    step();
    chk("per_ti_again", ti_bit(), 32'h1);
    wr(14'h44, 32'h1, 32'h1);
    for (int j = 0; j < 7; j++) step();
    rd(14'h42, v); chk("coin_zero", v, 32'h0);
    wr(14'h44, 32'h1, 32'h1);
    chk("set_beats_clr", ti_bit(), 32'h1);
    wr(14'h44, 32'h1, 32'h1);
    for (int j = 0; j < 7; j++) step();
    rd(14'h42, v); chk("wr_zero", v, 32'h0);
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
    chk("write_beats_fire", ti_bit(), 32'h0);
    rd(14'h42, v); chk("write_reload", v, 32'd8);
    wr(14'h41, 32'hFFFF_FFFF, 32'h0);

    // Hardware interrupt through synchronizer and request FSM
    crmd_ie = 1'b1; ecfg_lie = 13'h004; hw_int_raw = 8'h01;
    for (int j = 1; j <= SYNC_LAT; j++) begin
      step();
      chk("hw_lat", {31'b0, estat_is[2]}, (j >= SYNC_LAT) ? 32'h1 : 32'h0);
      chk("req_pre", {31'b0, has_int}, 32'h0);
    end
    step();
    chk("req_set", {31'b0, has_int}, 32'h1);
    int_ack = 1'b1;
    step();
    chk("hold_low", {31'b0, has_int}, 32'h0);
    int_ack = 1'b0; crmd_ie = 1'b0;
    step();
    chk("idle_low", {31'b0, has_int}, 32'h0);
    step();
    chk("ie_off_low", {31'b0, has_int}, 32'h0);

    // Pending drop in REQ without ack
    crmd_ie = 1'b1;
    step();
    chk("req2_set", {31'b0, has_int}, 32'h1);
    ecfg_lie = 13'h0;
    step();
    chk("req_drop", {31'b0, has_int}, 32'h0);
    step();
    chk("idle_stay", {31'b0, has_int}, 32'h0);
    ecfg_lie = 13'h004;
    step();
    chk("idle_to_req", {31'b0, has_int}, 32'h1);
    ipi_int_in = 1'b1; sw_is = 2'b10;
    #1;
    chk("ipi_sw_direct", {19'b0, estat_is[12], estat_is[1:0]}, 32'h6);
    crmd_ie = 1'b0; ecfg_lie = '0; hw_int_raw = '0; ipi_int_in = 1'b0; sw_is = '0;
    for (int j = 0; j < 4; j++) step();

    // Randomized interrupt phase against a queue/boolean model
    hwq = {};
    for (int j = 0; j < SYNC_LAT; j++) hwq.push_back(8'h0);
    m_has = 1'b0; m_hold = 1'b0;
    for (int c = 0; c < 300; c++) begin
      hw_int_raw = 8'($urandom);
      ipi_int_in = 1'($urandom_range(0, 1));
      sw_is      = 2'($urandom_range(0, 3));
      ecfg_lie   = ($urandom_range(0, 2) == 0) ? 13'h0 : 13'($urandom);
      crmd_ie    = ($urandom_range(0, 3) != 0);
      int_ack    = ($urandom_range(0, 3) == 0);
      #1;
      exp_is = {ipi_int_in, 1'b0, 1'b0, hwq[0], sw_is};
      chk("rnd_estat", {19'b0, estat_is}, {19'b0, exp_is});
      chk("rnd_has_int", {31'b0, has_int}, {31'b0, m_has});
      pend = (|(exp_is & ecfg_lie)) & crmd_ie;
      if (m_hold) begin
        m_has = 1'b0; m_hold = 1'b0;
      end else if (m_has && int_ack) begin
        m_has = 1'b0; m_hold = 1'b1;
      end else begin
        m_has = pend;
      end
      void'(hwq.pop_front());
      hwq.push_back(hw_int_raw);
      step();
    end
    hw_int_raw = '0; ipi_int_in = 1'b0; sw_is = '0; int_ack = 1'b0;
    crmd_ie = 1'b0; ecfg_lie = '0;
    for (int j = 0; j < 4; j++) step();

    // Reset mid-count and mid-request
    wr(14'h40, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    crmd_ie = 1'b1; ecfg_lie = 13'h800;
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
    for (int j = 0; j < 12; j++) step();
    rd(14'h42, v); chk("pre_rst_tval", v, 32'd5);
    chk("pre_rst_ti", ti_bit(), 32'h1);
    chk("pre_rst_has", {31'b0, has_int}, 32'h1);
    reset = 1'b1;
    step();
    rd(14'h42, v); chk("mid_rst_tval", v, 32'h0);
    rd(14'h41, v); chk("mid_rst_tcfg", v, 32'h0);
    rd(14'h40, v); chk("mid_rst_tid", v, TID_RST);
    chk("mid_rst_ti", ti_bit(), 32'h0);
    chk("mid_rst_has", {31'b0, has_int}, 32'h0);
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_timer_ctrl.md
# int_timer_ctrl

Interrupt and stable-timer controller feeding the WB-stage CSR file. It synchronizes external hardware interrupts, owns the LoongArch timer CSRs (TID, TCFG, TVAL, TICLR), and assembles the pending-interrupt vector ESTAT.IS[12:0]. It raises a single interrupt request that WB holds until the interrupt is committed, so one event is never taken twice. It sits beside `csr` in WB: the CSR write port fans out to both, and `csr` muxes this block's read data for timer CSR numbers.

## Interface
- TID_RESET, 32'h0, reset value of CSR TID
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- hw_int_raw  in  8  asynchronous level interrupt lines, map to IS[9:2]
- ipi_int_in  in  1  inter-processor interrupt level, maps to IS[12]
- sw_is  in  2  software interrupt bits IS[1:0], owned by `csr`
- crmd_ie  in  1  global interrupt enable
- ecfg_lie  in  13  local enable mask
- csr_we  in  1  CSR write strobe, already qualified by ws_valid
- csr_num  in  14  CSR number, shared with the `csr` read/write port
- csr_wmask  in  32  bit write mask
- csr_wvalue  in  32  write data
- int_ack  in  1  WB commits an interrupt this cycle
- csr_rvalue  out  32  read data for TID/TCFG/TVAL/TICLR, 0 for other numbers
- estat_is  out  13  pending vector {ipi, TI, 1'b0, hw[7:0], sw[1:0]}
- has_int  out  1  interrupt request to WB

## Operation
- Registers: TID[31:0]; TCFG {InitVal[31:2], Periodic[1], En[0]}; TVAL[31:0] (read-only); TI pending bit (IS[11]).
- Masked writes apply `new = (old & ~wmask) | (wvalue & wmask)` to TID (0x40) and TCFG (0x41). A TCFG write also loads TVAL with {new InitVal, 2'b00}.
- TICLR (0x44): a write with wmask[0] & wvalue[0] clears TI. TICLR always reads 0. Writes to TVAL (0x42) are ignored.
- Counter behaviour when En=1 and there is no TCFG write this cycle:
  - TVAL != 0: decrement TVAL.
  - TVAL == 0: set TI.
    - If Periodic: reload TVAL with {InitVal, 2'b00}.
    - Otherwise: TVAL becomes 32'hFFFF_FFFF and En clears.
- When En=0, TVAL holds its value.
- Simultaneous events:
  - TI set and TICLR clear in the same cycle: set wins.
  - TCFG write and TVAL reaching 0 in the same cycle: the write wins and TI is not set.
- Hardware interrupts are level-sensitive and pass through the synchronizer (see Configuration). IS[10] reads 0.
- `pend = |(estat_is & ecfg_lie) & crmd_ie`.
- Request FSM:
  - IDLE: has_int=0. Go to REQ when pend=1.
  - REQ: has_int=1. On int_ack go to HOLD. If pend drops without an ack, go back to IDLE.
  - HOLD: has_int=0 for exactly one cycle, covering the cycle in which `csr` clears CRMD.IE. Then go to IDLE.
- int_ack in IDLE or HOLD is ignored.

## Timing
- Reset values:
  - TID = TID_RESET.
  - TCFG, TVAL, TI = 0.
  - Synchronizer flops = 0.
  - FSM = IDLE, has_int = 0, csr_rvalue = 0, estat_is = {11'b0, sw_is}.
- csr_rvalue is combinational from csr_num and the current registers. A write in cycle N is visible on a read in cycle N+1.
- has_int is registered: pend=1 in cycle N gives has_int=1 in cycle N+1.
- Timer: after a TCFG write in cycle N with En=1 and InitVal field = k (TVAL = 4k), TI reads 1 in cycle N+4k+2.
- hw_int_raw to estat_is latency: 2 cycles with synchronization, 1 cycle without.
- Reset asserted mid-count or mid-request returns every register to its reset value on the next edge.

## Configuration
- INT_HW_SYNC_EN defined: hw_int_raw passes through two flops before reaching estat_is (metastability protection).
- INT_HW_SYNC_EN undefined: a single register stage is used.
- ipi_int_in and sw_is are never synchronized.

## Test plan
- Write TCFG = 32'h0000_0011 (InitVal field 4, En=1, one-shot) -> TVAL counts 16 down to 0, TI=1 at cycle N+18, then TVAL=32'hFFFF_FFFF and En=0; TI is set exactly once.
- Write TCFG = 32'h0000_000B (InitVal field 2, periodic) -> TI set, TVAL reloads to 8. Clear via TICLR on a cycle where TVAL != 0; TI sets again 9 cycles after the reload.
- TICLR write on the same cycle TVAL reaches 0 -> TI reads 1 in the next cycle.
- Set crmd_ie=1, ecfg_lie=13'h004, raise hw_int_raw[0] -> estat_is[2]=1 after 2 cycles (INT_HW_SYNC_EN), has_int=1 one cycle later. Assert int_ack -> has_int=0 for the HOLD cycle; then drop crmd_ie -> has_int stays 0.
- In REQ, drop ecfg_lie to 0 with no int_ack -> has_int falls the next cycle and the FSM returns to IDLE.
- Assert reset while TVAL=5, TI=1 and has_int=1 -> the next cycle shows TVAL=0, TI=0, has_int=0, and TID=TID_RESET.
